// File: rtl/mem_burst_ram.sv
// Clocked, byte-writable backing memory for the cache.
// Serves single-word and critical-word-first line bursts after a fixed access latency.
module mem_burst_ram #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned LATENCY   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_burst,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned LOW_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LOW_W-1:0] LAST_BURST = LOW_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StWait, StXfer} state_e;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_e              state_q;
    logic [CNT_W-1:0]    lat_q;
    logic [LOW_W-1:0]    beat_q;
    logic                we_q;
    logic                burst_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_done_q;
    logic                wr_ready_q;

    logic [LOW_W-1:0]    last_idx;
    logic                last_beat;
    logic [LOW_W-1:0]    beat_next;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic                wr_fire;
    logic                start_xfer;
    logic                s_we;
    logic                s_burst;
    logic [ADDR_W-1:0]   s_addr;
    logic [ADDR_W-1:0]   s_first;
    logic                s_single;

    // Beats wrap inside the aligned line; single transfers stay at the request address.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                    input logic              b,
                                                    input logic [LOW_W-1:0]  k);
        logic [LOW_W-1:0]  low;
        logic [ADDR_W-1:0] r;
        low = a[LOW_W-1:0] + k;
        r   = a;
        if (b && BURST_LEN > 1) r[LOW_W-1:0] = low;
        return r;
    endfunction

    always_comb begin
        last_idx   = (burst_q && BURST_LEN > 1) ? LAST_BURST : '0;
        last_beat  = (beat_q == last_idx);
        beat_next  = beat_q + 1'b1;
        cur_addr   = beat_addr(addr_q, burst_q, beat_q);
        next_addr  = beat_addr(addr_q, burst_q, beat_next);
        wr_fire    = (state_q == StXfer) && we_q && wr_valid;

        // Transfer parameters seen on the edge that enters XFER.
        s_we       = (state_q == StIdle) ? req_we    : we_q;
        s_burst    = (state_q == StIdle) ? req_burst : burst_q;
        s_addr     = (state_q == StIdle) ? req_addr  : addr_q;
        s_first    = beat_addr(s_addr, s_burst, '0);
        s_single   = !(s_burst && BURST_LEN > 1);
        start_xfer = ((state_q == StIdle) && req_valid && (LATENCY == 1)) ||
                     ((state_q == StWait) && (lat_q == CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) mem[cur_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lat_q      <= '0;
            beat_q     <= '0;
            we_q       <= 1'b0;
            burst_q    <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_done_q  <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        burst_q <= req_burst;
                        addr_q  <= req_addr;
                        be_q    <= req_be;
                        lat_q   <= CNT_W'(LATENCY - 1);
                        beat_q  <= '0;
                        state_q <= (LATENCY == 1) ? StXfer : StWait;
                    end
                end
                StWait: begin
                    lat_q <= lat_q - 1'b1;
                    if (lat_q == CNT_W'(1)) state_q <= StXfer;
                end
                StXfer: begin
                    if (!we_q) begin
                        if (last_beat) begin
                            state_q    <= StIdle;
                            rd_valid_q <= 1'b0;
                            rd_done_q  <= 1'b0;
                        end else begin
                            beat_q    <= beat_next;
                            rd_data_q <= mem[next_addr];
                            rd_done_q <= (beat_next == last_idx);
                        end
                    end else if (wr_valid) begin
                        if (last_beat) begin
                            state_q    <= StIdle;
                            wr_ready_q <= 1'b0;
                        end else begin
                            beat_q <= beat_next;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (start_xfer) begin
                if (s_we) begin
                    wr_ready_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= mem[s_first];
                    rd_done_q  <= s_single;
                end
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign req_ready = !busy;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    // Write completion depends on this cycle's wr_valid, so it cannot be registered.
    assign done      = rd_done_q | (wr_fire && last_beat);

endmodule

// File: tb/tb_mem_burst_ram.sv
// Self-checking bench for mem_burst_ram: directed table, hand-built corner sequences,
// randomized transfers against a word-array reference model.
module tb_mem_burst_ram;

    localparam int BL  = 4;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_burst;
    logic [19:0] req_addr;
    logic [3:0]  req_be;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data, rd_data;
    logic        rd_valid, done, busy;

    logic        l_req_valid [2];
    logic        l_req_ready [2];
    logic        l_req_we    [2];
    logic [7:0]  l_req_addr  [2];
    logic        l_wr_valid  [2];
    logic        l_wr_ready  [2];
    logic [31:0] l_wr_data   [2];
    logic        l_rd_valid  [2];
    logic [31:0] l_rd_data   [2];
    logic        l_done      [2];
    logic        l_busy      [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    mem_burst_ram #(.DATA_W(32), .ADDR_W(20), .BURST_LEN(BL), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_burst(req_burst), .req_addr(req_addr), .req_be(req_be),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy)
    );

    for (genvar g = 0; g < 2; g++) begin : g_lat
        mem_burst_ram #(.DATA_W(32), .ADDR_W(8), .BURST_LEN(BL),
                        .LATENCY((g == 0) ? 1 : 6)) u_lat (
            .clk(clk), .rst_n(rst_n), .req_valid(l_req_valid[g]), .req_ready(l_req_ready[g]),
            .req_we(l_req_we[g]), .req_burst(1'b0), .req_addr(l_req_addr[g]), .req_be(4'hf),
            .wr_valid(l_wr_valid[g]), .wr_ready(l_wr_ready[g]), .wr_data(l_wr_data[g]),
            .rd_valid(l_rd_valid[g]), .rd_data(l_rd_data[g]), .done(l_done[g]),
            .busy(l_busy[g])
        );
    end

    typedef struct {
        bit               we;
        bit               burst;
        int               addr;
        logic [3:0]       be;
        logic [3:0][31:0] wd;
        logic [3:0][31:0] exp;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word visited by beat k: wrap within the aligned line of BL words.
    function automatic int baddr(int a, bit b, int k);
        if (!b) return a;
        return (a - (a % BL)) + ((a % BL) + k) % BL;
    endfunction

    function automatic vec_t mk(bit we, bit burst, int addr, logic [3:0] be, logic [31:0] w0,
                                logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                                logic [31:0] e3);
        vec_t v;
        v.we = we; v.burst = burst; v.addr = addr; v.be = be;
        v.wd = '0; v.wd[0] = w0;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic model_write(int a, logic [3:0] be, logic [31:0] d);
        logic [31:0] w;
        w = model.exists(a) ? model[a] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        model[a] = w;
    endtask

    // Entered and left at 1ns after a rising edge; outputs sampled 1ns later.
    task automatic run_txn(input bit we, input bit burst, input int addr, input logic [3:0] be,
                           input logic [3:0][31:0] wd, input int stall_beat,
                           input int stall_len, input bit rnd_stall,
                           output logic [3:0][31:0] rd);
        int n, k, st, budget, a;
        bit v;
        n = burst ? BL : 1;
        rd = '0;
        req_valid = 1'b1; req_we = we; req_burst = burst; req_addr = 20'(addr);
        req_be = be; wr_valid = 1'b0;
        #1 chk1("req_ready_idle", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 20'($urandom); req_be = 4'($urandom);
        for (int c = 1; c < LAT; c++) begin
            wr_valid = 1'($urandom); wr_data = $urandom;
            #1;
            chk1("wait_busy", busy, 1'b1);
            chk1("wait_req_ready", req_ready, 1'b0);
            chk1("wait_rd_valid", rd_valid, 1'b0);
            chk1("wait_wr_ready", wr_ready, 1'b0);
            chk1("wait_done", done, 1'b0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        if (!we) begin
            for (k = 0; k < n; k++) begin
                #1;
                a = baddr(addr, burst, k);
                chk1("rd_valid", rd_valid, 1'b1);
                chk1("rd_done", done, k == n - 1);
                if (model.exists(a)) chk32("rd_data_model", rd_data, model[a]);
                rd[k] = rd_data;
                @(posedge clk); #1;
            end
        end else begin
            k = 0; st = 0; budget = 64;
            while (k < n && budget > 0) begin
                if (k == stall_beat && st < stall_len) begin v = 1'b0; st++; end
                else if (rnd_stall && $urandom_range(0, 3) == 0) v = 1'b0;
                else v = 1'b1;
                wr_valid = v;
                wr_data  = v ? wd[k] : $urandom;
                #1;
                chk1("wr_ready", wr_ready, 1'b1);
                chk1("wr_done", done, v && (k == n - 1));
                chk1("wr_busy", busy, 1'b1);
                if (v) begin
                    model_write(baddr(addr, burst, k), be, wd[k]);
                    k++;
                end
                @(posedge clk); #1;
                wr_valid = 1'b0;
                budget--;
            end
            if (k < n) chk32("write_beats_before_budget", 32'(k), 32'(n));
        end
        #1;
        chk1("end_busy", busy, 1'b0);
        chk1("end_req_ready", req_ready, 1'b1);
        chk1("end_rd_valid", rd_valid, 1'b0);
        chk1("end_done", done, 1'b0);
        chk1("end_wr_ready", wr_ready, 1'b0);
    endtask

    task automatic lat_test(input int idx, input int lat);
        logic [31:0] d;
        d = 32'h5A5A0000 + 32'(lat);
        l_req_valid[idx] = 1'b1; l_req_we[idx] = 1'b1; l_req_addr[idx] = 8'h33;
        l_wr_valid[idx] = 1'b1; l_wr_data[idx] = d;
        #1 chk1("lat_req_ready_idle", l_req_ready[idx], 1'b1);
        @(posedge clk); #1;
        l_req_valid[idx] = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            #1;
            chk1("lat_wr_ready", l_wr_ready[idx], c == lat);
            chk1("lat_wr_done", l_done[idx], c == lat);
            chk1("lat_wr_req_ready", l_req_ready[idx], 1'b0);
            @(posedge clk); #1;
        end
        l_wr_valid[idx] = 1'b0;
        #1 chk1("lat_wr_end_busy", l_busy[idx], 1'b0);
        l_req_valid[idx] = 1'b1; l_req_we[idx] = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= lat; c++) begin
            // Stray request while busy must be dropped.
            l_req_valid[idx] = (c == 1);
            l_req_addr[idx]  = 8'h10;
            #1;
            chk1("lat_rd_valid", l_rd_valid[idx], c == lat);
            chk1("lat_rd_done", l_done[idx], c == lat);
            chk1("lat_rd_req_ready", l_req_ready[idx], 1'b0);
            chk1("lat_rd_busy", l_busy[idx], 1'b1);
            if (c == lat) chk32("lat_rd_data", l_rd_data[idx], d);
            @(posedge clk); #1;
        end
        l_req_valid[idx] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk1("lat_idle_rd_valid", l_rd_valid[idx], 1'b0);
            chk1("lat_idle_busy", l_busy[idx], 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t             tbl [10];
        logic [3:0][31:0] wd, rd;
        logic [31:0]      old6, old7;
        int               n;

        tbl[0] = mk(1, 0, 16, 4'hf, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 16, 4'hf, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[2] = mk(1, 0, 5, 4'hf, 32'h11223344, 0, 0, 0, 0);
        tbl[3] = mk(1, 0, 5, 4'b0101, 32'hAABBCCDD, 0, 0, 0, 0);
        tbl[4] = mk(0, 0, 5, 4'hf, 0, 32'h11BB33DD, 0, 0, 0);
        tbl[5] = mk(1, 0, 8, 4'hf, 32'd8, 0, 0, 0, 0);
        tbl[6] = mk(1, 0, 9, 4'hf, 32'd9, 0, 0, 0, 0);
        tbl[7] = mk(1, 0, 10, 4'hf, 32'd10, 0, 0, 0, 0);
        tbl[8] = mk(1, 0, 11, 4'hf, 32'd11, 0, 0, 0, 0);
        tbl[9] = mk(0, 1, 10, 4'hf, 0, 32'd10, 32'd11, 32'd8, 32'd9);

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_burst = 1'b0; req_addr = '0; req_be = '0;
        wr_valid = 1'b0; wr_data = '0;
        for (int i = 0; i < 2; i++) begin
            l_req_valid[i] = 1'b0; l_req_we[i] = 1'b0; l_req_addr[i] = '0;
            l_wr_valid[i] = 1'b0; l_wr_data[i] = '0;
        end
        #3;
        chk1("reset_req_ready", req_ready, 1'b1);
        chk1("reset_wr_ready", wr_ready, 1'b0);
        chk1("reset_rd_valid", rd_valid, 1'b0);
        chk32("reset_rd_data", rd_data, 32'h0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Give the region under test known contents.
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < BL; k++) wd[k] = 32'hC0DE0000 + 32'(b * BL + k);
            run_txn(1, 1, b * BL, 4'hf, wd, -1, 0, 0, rd);
        end

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].we, tbl[i].burst, tbl[i].addr, tbl[i].be, tbl[i].wd, -1, 0, 0, rd);
            n = tbl[i].burst ? BL : 1;
            if (!tbl[i].we) for (int k = 0; k < n; k++) chk32("table_rd", rd[k], tbl[i].exp[k]);
        end

        // Burst write with wr_valid low for two cycles between beats 1 and 2.
        for (int k = 0; k < BL; k++) wd[k] = 32'hF00D0000 + 32'(k);
        run_txn(1, 1, 0, 4'hf, wd, 2, 2, 0, rd);
        run_txn(0, 1, 0, 4'hf, wd, -1, 0, 0, rd);
        for (int k = 0; k < BL; k++) chk32("stall_readback", rd[k], 32'hF00D0000 + 32'(k));

        // Reset after two beats of a burst write to word 4.
        old6 = model[6];
        old7 = model[7];
        req_valid = 1'b1; req_we = 1'b1; req_burst = 1'b1; req_addr = 20'd4; req_be = 4'hf;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin @(posedge clk); #1; end
        wr_valid = 1'b1; wr_data = 32'hA0A0A0A0;
        @(posedge clk); #1;
        wr_data = 32'hA1A1A1A1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        model[4] = 32'hA0A0A0A0;
        model[5] = 32'hA1A1A1A1;
        chk1("mid_busy", busy, 1'b1);
        chk1("mid_wr_ready", wr_ready, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("arst_req_ready", req_ready, 1'b1);
        chk1("arst_wr_ready", wr_ready, 1'b0);
        chk1("arst_rd_valid", rd_valid, 1'b0);
        chk32("arst_rd_data", rd_data, 32'h0);
        chk1("arst_done", done, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(0, 1, 4, 4'hf, wd, -1, 0, 0, rd);
        chk32("arst_word4", rd[0], 32'hA0A0A0A0);
        chk32("arst_word5", rd[1], 32'hA1A1A1A1);
        chk32("arst_word6", rd[2], old6);
        chk32("arst_word7", rd[3], old7);

        lat_test(0, 1);
        lat_test(1, 6);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < BL; k++) wd[k] = $urandom;
            run_txn(1'($urandom), 1'($urandom), int'($urandom_range(0, 31)), 4'($urandom),
                    wd, -1, 0, 1, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
